// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider bundle: operands and start/annul from EX, result/ready/stall back.
// Single clock domain; the divider owns result_o, ready_o and stallreq_o.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider sequencer: WIDTH+1 cycles to ready_o (2 on /0, 1 on |a|<|b| with DIV_EARLY_EXIT_EN).
// stallreq_o holds EX while start_i is up until the result is ready; annul_i flushes back to FREE.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   bus
);
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] ON     = 2'd2;
    localparam logic [1:0] END    = 2'd3;

    logic [1:0]           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [WIDTH-1:0]     dividend_q, dividend_d;
    logic [WIDTH-1:0]     divisor_q,  divisor_d;
    logic [WIDTH-1:0]     rem_q,      rem_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q,  neg_rem_d;
    logic [2*WIDTH-1:0]   result_q,   result_d;
    logic                 ready_q,    ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     diff;
    logic                 qbit;
    logic [WIDTH-1:0]     rem_nxt, quot_nxt, rem_fix, quot_fix;
    logic                 early_exit;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign mag1    = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign mag2    = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = (mag1 < mag2);
`else
    assign early_exit = 1'b0;
`endif

    // The shifted remainder needs WIDTH+1 bits: rem < divisor can reach 2^WIDTH-2.
    assign rem_sh   = {rem_q, dividend_q[WIDTH-1]};
    assign diff     = {1'b0, rem_sh} - {2'b00, divisor_q};
    assign qbit     = ~diff[WIDTH+1];
    assign rem_nxt  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quot_nxt = {dividend_q[WIDTH-2:0], qbit};
    assign quot_fix = neg_quot_q ? (~quot_nxt + 1'b1) : quot_nxt;
    assign rem_fix  = neg_rem_q  ? (~rem_nxt  + 1'b1) : rem_nxt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else if (early_exit) begin
                        state_d  = END;
                        result_d = {bus.opdata1_i, {WIDTH{1'b0}}};
                        ready_d  = 1'b1;
                    end else begin
                        state_d    = ON;
                        dividend_d = mag1;
                        divisor_d  = mag2;
                        rem_d      = '0;
                        cnt_d      = '0;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end
            BYZERO: begin
                state_d  = END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ON: begin
                dividend_d = quot_nxt;
                rem_d      = rem_nxt;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d  = END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end
            end
            default: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
        endcase

        // A flush overrides both a pending completion and a held start.
        if (bus.annul_i && (state_q != FREE)) begin
            state_d    = FREE;
            cnt_d      = '0;
            dividend_d = '0;
            divisor_d  = '0;
            rem_d      = '0;
            result_d   = '0;
            ready_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & (state_q != END);
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table plus annul, reset and hold sequences.
module tb_div_ctrl;
    localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 33;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    div_ctrl_if #(.WIDTH(W)) bus ();

    div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in FREE; returns at a negedge with start low.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input int hold);
        int lat;
        int stall_cnt;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        #1;
        lat = 0;
        stall_cnt = 0;
        while (!bus.ready_o && lat < 100) begin
            if (bus.stallreq_o) stall_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 5) begin
                bus.opdata1_i    = 32'hDEADBEEF;
                bus.opdata2_i    = 32'h1;
                bus.signed_div_i = ~sgn;
            end
        end
        check({name, " ready"}, 64'(bus.ready_o), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " stall cycles"}, 64'(stall_cnt), 64'(exp_lat));
        check({name, " result"}, bus.result_o, exp_res);
        check({name, " stall in ready"}, 64'(bus.stallreq_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " hold ready"}, 64'(bus.ready_o), 64'd1);
            check({name, " hold result"}, bus.result_o, exp_res);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, " drop ready"}, 64'(bus.ready_o), 64'd0);
        check({name, " drop result"}, bus.result_o, 64'd0);
    endtask

    vec_t vecs[14];
    int   seen_ready;

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        vecs[0]  = '{"divu 100/7",       1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},               33};
        vecs[1]  = '{"div -7/2",         1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33};
        vecs[2]  = '{"div 7/-2",         1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},         33};
        vecs[3]  = '{"div min/-1",       1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000},         33};
        vecs[4]  = '{"divu 5/0",         1'b0, 32'd5,        32'd0,        64'h0,                         2};
        vecs[5]  = '{"divu 9/3",         1'b0, 32'd9,        32'd3,        {32'd0, 32'd3},                33};
        vecs[6]  = '{"divu 3/10",        1'b0, 32'd3,        32'd10,       {32'd3, 32'd0},                LAT_SMALL};
        vecs[7]  = '{"div -3/10",        1'b1, 32'hFFFFFFFD, 32'd10,       {32'hFFFFFFFD, 32'd0},         LAT_SMALL};
        vecs[8]  = '{"div -100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},        33};
        vecs[9]  = '{"divu max/max",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'd0, 32'd1},                33};
        vecs[10] = '{"divu max/2",       1'b0, 32'hFFFFFFFF, 32'd2,        {32'd1, 32'h7FFFFFFF},         33};
        vecs[11] = '{"divu 0/5",         1'b0, 32'd0,        32'd5,        64'h0,                         LAT_SMALL};
        vecs[12] = '{"div min/2",        1'b1, 32'h80000000, 32'd2,        {32'd0, 32'hC0000000},         33};
        vecs[13] = '{"divu 2^31/max",    1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},         LAT_SMALL};

        #1;
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        check("reset stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 14; v++) begin
            run_div(vecs[v].name, vecs[v].sgn, vecs[v].a, vecs[v].b,
                    vecs[v].exp_res, vecs[v].exp_lat, (v == 0) ? 5 : 0);
        end

        // Annul mid-ON, then confirm nothing completes later.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.annul_i = 1'b1;
        #1;
        check("annul stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("annul ready", 64'(bus.ready_o), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        check("annul stall after", 64'(bus.stallreq_o), 64'd0);
        seen_ready = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) seen_ready++;
        end
        check("annul no late ready", 64'(seen_ready), 64'd0);
        run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        // Reset asserted mid-ON.
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("rst on ready", 64'(bus.ready_o), 64'd0);
        check("rst on result", bus.result_o, 64'd0);
        check("rst on stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted while the result is held in END.
        bus.start_i = 1'b1;
        for (int i = 0; i < 100 && !bus.ready_o; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("end reached", bus.result_o, {32'd2, 32'd14});
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("rst end ready", 64'(bus.ready_o), 64'd0);
        check("rst end result", bus.result_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div("after reset -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage 32-bit divider used by DIV/DIVU.
- Latches operands on a start request, runs a radix-2 restoring division FSM, and holds the pipeline stalled until the 64-bit {remainder, quotient} is ready for HI/LO write-back.
- Sits beside the EX ALU. EX drives start/annul; stallreq_o feeds the pipeline stall controller.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  input  WIDTH  dividend (rs)
- opdata2_i  input  WIDTH  divisor (rt)
- start_i  input  1  division request, held high by EX until the result is taken
- annul_i  input  1  cancel the in-flight division (flush)
- result_o  output  2*WIDTH  {remainder[63:32] → HI, quotient[31:0] → LO}
- ready_o  output  1  result_o valid
- stallreq_o  output  1  pipeline stall request

Behaviour:
- Reset (rst low, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers=0.
- States: FREE, BYZERO, ON, END. All registered; stallreq_o is the only combinational output.
- FREE:
  - start_i=1 & annul_i=0 & divisor=0 → BYZERO.
  - start_i=1 & annul_i=0 & divisor≠0 → ON. On this edge, latch sign flags and operand magnitudes (negate negative operands when signed_div_i=1), and clear cnt and the partial remainder.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: one cycle, then → END with result 64'h0.
- ON:
  - Each cycle, shift {rem, dividend} left by 1 and compute trial = rem - divisor.
  - If trial is non-negative: rem=trial, quotient bit=1. Otherwise quotient bit=0.
  - cnt increments each cycle.
  - After the WIDTH-th iteration (cnt==WIDTH-1 on entry), → END.
- Sign fix, applied on the ON→END edge:
  - Signed and operand signs differ → quotient negated.
  - Signed and dividend negative → remainder negated.
  - 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0; no trap.
- END: ready_o=1 and result_o valid. Stay in END while start_i=1. When start_i=0 → FREE, and ready_o=0 and result_o=0 the next cycle.
- Latency:
  - Normal path: start sampled at edge 0, ready_o high after edge WIDTH+1 (33 cycles for WIDTH=32).
  - Divide by zero: ready_o high after edge 2.
- annul_i:
  - In any state other than FREE, annul_i=1 → FREE next edge; ready_o=0, result_o=0; latched operands discarded.
  - annul_i has priority over start_i and over the count completing.
- stallreq_o = start_i & ~annul_i & (state≠END). It is high from the same cycle start_i rises and low in the cycle ready_o is high.
- Operand inputs and signed_div_i are ignored outside FREE; changes mid-operation have no effect.
- A new start requires a return to FREE: start_i must drop for at least one cycle between divisions.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in FREE with start, if divisor≠0 and |dividend| < |divisor| (unsigned magnitude compare), go directly → END with quotient 0 and remainder = original dividend (sign preserved). ready_o is high after edge 1.
- Undefined: all nonzero-divisor cases take the full WIDTH-cycle ON path; the magnitude comparator is not built.

Test Plan:
- DIVU 100 / 7, start held → stallreq_o high for 33 cycles, then ready_o=1, result_o={32'd2, 32'd14}; stallreq_o=0 in the ready cycle.
- DIV -7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / -2 → quotient -3, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → result_o={32'h0, 32'h80000000}, no hang. DIVU 5 / 0 → ready_o high after 2 edges, result_o=64'h0.
- Start DIVU 1000 / 3, assert annul_i for 1 cycle at cycle 10 → state FREE next edge, ready_o stays 0, stallreq_o=0. A following DIVU 9 / 3 returns {0, 3} with full latency.
- Hold start_i high in END for 5 cycles → ready_o and result_o stable. Drop start_i → ready_o=0 next edge. Toggle opdata1_i during ON → result unaffected.
- DIV_EARLY_EXIT_EN defined, DIVU 3 / 10 → ready_o after 1 edge, result_o={32'd3, 32'd0}. Macro undefined → same operands take 33 cycles with the identical result. Assert rst low mid-ON → all outputs 0 immediately.
